// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: default widths, the x0 register
// constant and the request record type.
package wb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 5;

    localparam logic [AW_DEF-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [AW_DEF-1:0]   addr;
        logic [XLEN_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback request bus plus register file write port. Building with
// WB_ARB_FWD_EN adds the read-address and bypass signals.
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;

    logic                 we3;
    logic [AW-1:0]        wa3;
    logic [XLEN-1:0]      wd3;
    logic [IW-1:0]        grant_id;

`ifdef WB_ARB_FWD_EN
    logic [AW-1:0]        ra1;
    logic [AW-1:0]        ra2;
    logic                 fwd1_hit;
    logic                 fwd2_hit;
    logic [XLEN-1:0]      fwd1_data;
    logic [XLEN-1:0]      fwd2_data;

    modport master (
        output req_valid, req_addr, req_data, ra1, ra2,
        input  req_ready, we3, wa3, wd3, grant_id,
               fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, ra1, ra2,
        output req_ready, we3, wa3, wd3, grant_id,
               fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
    );
`else
    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, we3, wa3, wd3, grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, we3, wa3, wd3, grant_id
    );
`endif

endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: selects the first set request at or after
// the pointer, wrapping modulo NREQ.
module rr_picker #(
    parameter  int NREQ = 3,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    int w_j;

    always_comb begin
        // NOTE: every output gets a default before the search loop, so no path leaves a latch.
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx      = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter feeding the register file write port from a
// registered stage. Optional same-cycle bypass: define WB_ARB_FWD_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);

    localparam int            IW   = $clog2(NREQ);
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    logic [IW-1:0]   r_ptr;
    logic            r_we;
    logic [AW-1:0]   r_wa;
    logic [XLEN-1:0] r_wd;
    logic [IW-1:0]   r_gid;

    logic [NREQ-1:0] w_zero;
    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic [IW-1:0]   w_ptr_next;
    logic [AW-1:0]   w_win_addr;
    logic [XLEN-1:0] w_win_data;

    // Writes to x0 are swallowed here and never compete for the write port.
    for (genvar g = 0; g < NREQ; g++) begin : g_split
        assign w_zero[g] = bus.req_valid[g] && (bus.req_addr[g*AW +: AW] == AW'(REG_ZERO));
        assign w_cand[g] = bus.req_valid[g] && (bus.req_addr[g*AW +: AW] != AW'(REG_ZERO));
    end

    rr_picker #(.NREQ(NREQ)) u_picker (
        .i_req   (w_cand),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_ptr_next = (w_idx == LAST) ? '0 : w_idx + 1'b1;
    assign w_win_addr = bus.req_addr[int'(w_idx)*AW +: AW];
    assign w_win_data = bus.req_data[int'(w_idx)*XLEN +: XLEN];

    assign bus.req_ready = reset ? '0 : (w_zero | w_grant);

    // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_we  <= 1'b0;
            r_wa  <= '0;
            r_wd  <= '0;
            r_gid <= '0;
        end else begin
            r_we <= w_any;
            if (w_any) begin
                r_ptr <= w_ptr_next;
                r_wa  <= w_win_addr;
                r_wd  <= w_win_data;
                r_gid <= w_idx;
            end
        end
    end

    assign bus.we3      = r_we;
    assign bus.wa3      = r_wa;
    assign bus.wd3      = r_wd;
    assign bus.grant_id = r_gid;

`ifdef WB_ARB_FWD_EN
    // Bypass covers the cycle where the write sits in the stage but is not yet in the file.
    assign bus.fwd1_hit  = r_we && (r_wa == bus.ra1) && (bus.ra1 != AW'(REG_ZERO));
    assign bus.fwd2_hit  = r_we && (r_wa == bus.ra2) && (bus.ra2 != AW'(REG_ZERO));
    assign bus.fwd1_data = r_wd;
    assign bus.fwd2_data = r_wd;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: reference round-robin model plus a
// scoreboard of expected register file writes.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct {
        wb_req_t req;
        int      id;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) bus ();

    wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];

    logic [NREQ-1:0] t_valid;
    logic [AW-1:0]   t_addr [NREQ];
    logic [XLEN-1:0] t_data [NREQ];

    int              m_ptr;
    logic [AW-1:0]   m_wa;
    logic [XLEN-1:0] m_wd;
    int              m_gid;

    logic [NREQ-1:0] obs_ready;
    int              obs_gid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = t_valid;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW]     = t_addr[i];
            bus.req_data[i*XLEN +: XLEN] = t_data[i];
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_wa  = '0;
        m_wd  = '0;
        m_gid = 0;
        sb.delete();
    endtask

    // Inputs already applied after a falling edge; checks ready, then the registered write.
    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        int              win;
        int              j;
        exp_t            e;
        exp_ready = '0;
        win       = -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (t_valid[j] && t_addr[j] == REG_ZERO) exp_ready[j] = 1'b1;
            if (t_valid[j] && t_addr[j] != REG_ZERO && win < 0) begin
                win          = j;
                exp_ready[j] = 1'b1;
            end
        end
        #1;
        obs_ready = bus.req_ready;
        check("req_ready", obs_ready, exp_ready);
        if (win >= 0) begin
            e.req.addr = t_addr[win];
            e.req.data = t_data[win];
            e.id       = win;
            sb.push_back(e);
            m_ptr = (win + 1) % NREQ;
        end
        @(posedge clk);
        #1;
        obs_gid = int'(bus.grant_id);
        check("we3", bus.we3, win >= 0);
        if (win >= 0 && sb.size() > 0) begin
            e = sb.pop_front();
            m_wa  = e.req.addr;
            m_wd  = e.req.data;
            m_gid = e.id;
        end
        check("wa3", bus.wa3, m_wa);
        check("wd3", bus.wd3, m_wd);
        check("grant_id", bus.grant_id, m_gid);
    endtask

    task automatic req(input logic [NREQ-1:0] v,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
        @(negedge clk);
        t_valid   = v;
        t_addr[0] = a0;
        t_addr[1] = a1;
        t_addr[2] = a2;
        t_data[0] = d0;
        t_data[1] = d1;
        t_data[2] = d2;
        drive();
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int rr_exp [6] = '{0, 1, 2, 0, 1, 2};
    int rr_order [6];
    int rr_cnt [NREQ];
    int waited;
    bit got2;

    initial begin
        t_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i] = '0;
            t_data[i] = '0;
        end
        drive();
`ifdef WB_ARB_FWD_EN
        bus.ra1 = '0;
        bus.ra2 = '0;
`endif
        model_reset();

        // Reset values and ready suppression while reset is high.
        @(negedge clk);
        @(negedge clk);
        check("rst_we3", bus.we3, 1'b0);
        check("rst_wa3", bus.wa3, 5'd0);
        check("rst_wd3", bus.wd3, 32'd0);
        check("rst_gid", bus.grant_id, 2'd0);
        t_valid   = 3'b111;
        t_addr[0] = 5'd1;
        t_addr[1] = 5'd0;
        t_addr[2] = 5'd3;
        drive();
        #1;
        check("rst_ready", bus.req_ready, 3'b000);
        t_valid = '0;
        drive();
        @(negedge clk);
        reset = 1'b0;

        // A pending write is discarded by a mid-cycle reset.
        req(3'b001, 5'd4, 5'd0, 5'd0, 32'h11, 32'h0, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_ready", bus.req_ready, 3'b000);
        check("midrst_we3", bus.we3, 1'b0);
        check("midrst_wa3", bus.wa3, 5'd0);
        check("midrst_wd3", bus.wd3, 32'd0);
        check("midrst_gid", bus.grant_id, 2'd0);
        t_valid = '0;
        drive();
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // First transaction after reset.
        req(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
        check("first_ready", obs_ready, 3'b001);
        check("first_we3", bus.we3, 1'b1);
        check("first_wa3", bus.wa3, 5'd5);
        check("first_wd3", bus.wd3, 32'hDEADBEEF);
        check("first_gid", bus.grant_id, 2'd0);

        // Bring the pointer back to 0, then all three contend for 6 cycles.
        req(3'b100, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h33);
        for (int k = 0; k < NREQ; k++) rr_cnt[k] = 0;
        for (int c = 0; c < 6; c++) begin
            req(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0 + 32'(c), 32'hB0 + 32'(c), 32'hC0 + 32'(c));
            rr_order[c] = obs_gid;
            for (int k = 0; k < NREQ; k++) if (obs_ready[k]) rr_cnt[k]++;
        end
        for (int c = 0; c < 6; c++) check($sformatf("rr_order%0d", c), rr_order[c], rr_exp[c]);
        for (int k = 0; k < NREQ; k++) check($sformatf("rr_cnt%0d", k), rr_cnt[k], 2);

        // x0 requests are consumed alongside a real grant, and alone produce no write.
        req(3'b011, 5'd0, 5'd7, 5'd0, 32'h55, 32'h77, 32'h0);
        check("x0_ready", obs_ready, 3'b011);
        check("x0_wa3", bus.wa3, 5'd7);
        req(3'b001, 5'd0, 5'd0, 5'd0, 32'h66, 32'h0, 32'h0);
        check("x0only_ready", obs_ready, 3'b001);
        check("x0only_we3", bus.we3, 1'b0);

        // Req2 with held data while req0/req1 keep requesting.
        req(3'b100, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h66);
        waited = 0;
        got2   = 1'b0;
        for (int c = 0; c < 3 && !got2; c++) begin
            req(3'b111, 5'd10, 5'd11, 5'd12, 32'h100, 32'h101, 32'hCAFE0002);
            waited++;
            if (obs_ready[2]) got2 = 1'b1;
        end
        check("hold_granted", got2, 1'b1);
        check("hold_wait", waited, 3);
        check("hold_wd3", bus.wd3, 32'hCAFE0002);

        // Idle cycles must not move the pointer.
        req(3'b001, 5'd8, 5'd0, 5'd0, 32'h88, 32'h0, 32'h0);
        for (int c = 0; c < 4; c++) req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        check("idle_we3", bus.we3, 1'b0);
        check("idle_wa3", bus.wa3, 5'd8);
        req(3'b111, 5'd13, 5'd14, 5'd15, 32'h1, 32'h2, 32'h3);
        check("idle_next_gid", obs_gid, 1);

`ifdef WB_ARB_FWD_EN
        req(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h1234, 32'h0);
        bus.ra1 = 5'd9;
        bus.ra2 = 5'd0;
        #1;
        check("fwd1_hit", bus.fwd1_hit, 1'b1);
        check("fwd1_data", bus.fwd1_data, 32'h1234);
        check("fwd2_hit", bus.fwd2_hit, 1'b0);
        req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        check("fwd1_hit_after", bus.fwd1_hit, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin arbiter that shares the register file's single write port among NREQ writeback sources (ALU, load unit, multiply/divide unit). Each source presents a valid/ready write request. The block selects at most one request per cycle and drives the register file write port (we3/wa3/wd3) from a registered stage. It sits between the execute/memory units and the register file; its outputs connect directly to the register file write port.

## Interface
- NREQ, 3, number of writeback requesters (2..8)
- XLEN, 32, data width
- AW, 5, register address width
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  destination register; requester i occupies [i*AW +: AW]
- req_data  in  NREQ*XLEN  write data; requester i occupies [i*XLEN +: XLEN]
- req_ready  out  NREQ  request accepted this cycle (combinational)
- we3  out  1  register file write enable (registered)
- wa3  out  AW  register file write address (registered)
- wd3  out  XLEN  register file write data (registered)
- grant_id  out  $clog2(NREQ)  requester index that produced the current we3 write (registered)
- ra1, ra2  in  AW  register file read addresses (only with WB_ARB_FWD_EN)
- fwd1_hit, fwd2_hit  out  1  a bypass is valid for ra1/ra2 (only with WB_ARB_FWD_EN)
- fwd1_data, fwd2_data  out  XLEN  bypass data (only with WB_ARB_FWD_EN)

## Operation
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. Requesters hold addr and data stable while valid is high and not yet ready. ready may depend on valid; valid must not depend on ready.
- x0 filter: a valid request with addr==0 gets ready=1 in the same cycle, whatever the arbitration outcome. It is consumed and produces no write.
- Arbitration: candidates are valid requests with addr!=0. The winner is the first candidate at or after rr_ptr, wrapping modulo NREQ. Only the winner among the candidates gets ready.
- rr_ptr update: on a grant, rr_ptr <= (winner+1) mod NREQ. With no grant, rr_ptr holds.
- Output stage, loaded every cycle:
  - we3 <= any grant
  - wa3/wd3/grant_id <= the winner's addr/data/index when granted; otherwise they hold their previous values.
- The register file never stalls, so there is no output backpressure. One write retires per cycle.
- Simultaneous x0 requests and a real grant: all are accepted in the same cycle.
- Reset: asserting reset clears all state immediately. req_ready is forced to 0 while reset is high, so no handshake completes in a reset cycle. A pending write in the output stage is discarded.

## Timing
- Reset values: we3=0, wa3=0, wd3=0, grant_id=0, rr_ptr=0. fwd*_hit=0 because it derives from we3.
- Latency: handshake at rising edge T → we3/wa3/wd3 valid during cycle T..T+1 → register file commits at edge T+1.
- Throughput: 1 write per cycle. A single continuously valid requester is granted every cycle.
- Fairness: a continuously valid requester waits at most NREQ-1 cycles between grants.
- req_ready is combinational from req_valid, req_addr and rr_ptr. There is no path from wd3 or we3 to req_ready.

## Configuration
- WB_ARB_FWD_EN defined:
  - Ports ra1/ra2/fwd*_hit/fwd*_data exist.
  - fwdN_hit = we3 && wa3==raN && raN!=0, combinational.
  - fwdN_data = wd3.
  - This covers the one-cycle window in which the write is registered but not yet committed to the register file.
- WB_ARB_FWD_EN undefined: those ports and their logic are absent. Consumers must stall one cycle on a read-after-write hazard.

## Structure
- Shared package wb_pkg:
  - localparams XLEN_DEF=32, AW_DEF=5
  - typedef wb_req_t {logic [AW-1:0] addr; logic [XLEN-1:0] data;}
  - REG_ZERO constant (5'd0)
- One sub-module, rr_picker:
  - Purely combinational.
  - Inputs: NREQ-bit request vector and pointer.
  - Outputs: one-hot grant, encoded index, any-grant.
- The pointer register, output stage and x0 filter live in wb_arbiter.

## Test plan
- Reset, then single request: reset asserted mid-cycle with we3=1 pending → we3 drops to 0 immediately. After release, req_valid=001, addr=5, data=0xDEADBEEF → ready=001 that cycle; next cycle we3=1, wa3=5, wd3=0xDEADBEEF, grant_id=0.
- Round-robin: all three valid for 6 cycles, addrs 1/2/3 → grant order 0,1,2,0,1,2. Each req_ready is high in exactly 2 cycles.
- x0 filter: req0 addr=0 and req1 addr=7 valid together → ready=011; one write only (wa3=7). Req0 alone at addr=0 → ready=001, we3 stays 0.
- Hold stability: req2 valid with rr_ptr=0 while req0/req1 keep requesting → req2 granted within 3 cycles; req2's data is unchanged until ready.
- Forwarding (WB_ARB_FWD_EN): write to r9 value 0x1234 registered, ra1=9, ra2=0 → fwd1_hit=1, fwd1_data=0x1234, fwd2_hit=0. One cycle later, with no new grant → fwd1_hit=0.
- Idle: no valid for 4 cycles → we3=0, wa3/wd3/grant_id hold, rr_ptr unchanged. Verify with the next contested grant order.
